// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage register.
package pipe_pkg;

  localparam int unsigned PIPE_LEVEL_W = 2;

  // The state encoding equals the occupancy, so level is the state itself
  typedef enum logic [PIPE_LEVEL_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_data_reg.sv
// Data register with async reset, synchronous clear and load enable.
module pipe_data_reg #(
  parameter int unsigned           WIDTH     = 32,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Priority: async reset, then clear, then enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (clear) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register: valid/ready handshake, synchronous flush,
// parametrised reset value and an optional two-entry skid buffer whose
// upstream ready comes straight from a flop.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SKID      = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [PIPE_LEVEL_W-1:0] level
);

  pipe_state_t      state;
  pipe_state_t      state_next;
  logic             in_xfer;
  logic             out_xfer;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  assign out_valid = (state != ST_EMPTY);
  assign level     = PIPE_LEVEL_W'(state);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Next-state and register-enable decode; flush overrides everything
  always_comb begin
    state_next = state;
    main_en    = 1'b0;
    skid_en    = 1'b0;
    main_d     = in_data;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_en    = 1'b1;
            state_next = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            main_en = 1'b1;
          end else if (in_xfer && SKID) begin
            skid_en    = 1'b1;
            state_next = ST_SKID;
          end else if (out_xfer) begin
            state_next = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            main_en    = 1'b1;
            main_d     = skid_q;
            state_next = ST_FULL;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  pipe_data_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

  generate
    if (SKID) begin : g_skid
      logic ready_q;

      pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
      );

      // Ready is precomputed from the next state so it leaves a flop directly
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_next != ST_SKID);
        end
      end

      assign in_ready = ready_q;
    end else begin : g_noskid
      assign skid_q   = RESET_VAL;
      assign in_ready = (state == ST_EMPTY) | out_ready;
    end
  endgenerate

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Elastic pipeline-stage register that generalises the plain reset/clear flop used between the pipeline stages of the MIPS core. It adds a valid/ready handshake, a synchronous flush, a parametrised reset value and an optional two-entry skid buffer. In skid mode the upstream `in_ready` comes straight from a flop, which breaks the combinational ready path between stages. It sits between any two pipeline stages, for example IF/ID or ID/EX.

## Interface
Parameters:
- `WIDTH`, 32: data width in bits.
- `RESET_VAL`, 0: value of `out_data` after reset or flush; `WIDTH` bits.
- `SKID`, 1: 1 selects the two-entry skid buffer with registered `in_ready`; 0 selects a single entry with `in_ready` = `~out_valid | out_ready`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `flush`, in, 1: synchronous clear of all entries; highest priority.
- `in_valid`, in, 1: upstream data valid.
- `in_ready`, out, 1: block can accept data.
- `in_data`, in, `WIDTH`: upstream data.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: downstream accepts data.
- `out_data`, out, `WIDTH`: stage output; driven directly from the main register.
- `level`, out, 2: occupancy, 0 to 2.

## Operation
- Transfer rules:
  - An input transfer occurs when `in_valid & in_ready`.
  - An output transfer occurs when `out_valid & out_ready`.
- Registers:
  - Main register drives `out_data`.
  - Skid register exists only when `SKID=1`.
- States:
  - `EMPTY` (`level` 0)
  - `FULL` (`level` 1)
  - `SKID` (`level` 2; reachable only when `SKID=1`)
- `EMPTY`: `out_valid`=0, `in_ready`=1. On an input transfer, main <= `in_data` and go to `FULL`.
- `FULL`: `out_valid`=1.
  - `in_ready` is 1 when `SKID=1`, or `out_ready` when `SKID=0`.
  - In and out transfer together: main <= `in_data`; stay in `FULL`.
  - In transfer only (`SKID=1`): skid <= `in_data`; go to `SKID`.
  - Out transfer only: go to `EMPTY`; main holds its last value.
  - Neither: hold.
- `SKID`: `in_ready`=0, `out_valid`=1. On an out transfer, main <= skid and go to `FULL`. Otherwise hold.
- Flush:
  - Next state is `EMPTY`; main and skid <= `RESET_VAL`.
  - Any input offered in the same cycle is dropped; `in_ready` is not forced low.
  - An output transfer in the same cycle completes from the downstream's view.
- Reset (asynchronous):
  - Takes effect immediately, including mid-transfer.
  - State `EMPTY`, main and skid = `RESET_VAL`.
  - Outputs: `out_valid`=0, `in_ready`=1, `out_data`=`RESET_VAL`, `level`=0.
- Ordering: data leaves in arrival order; no word is duplicated or lost except by flush or reset.

## Timing
- Latency: one cycle from input transfer to `out_valid` (edge N accepts, `out_valid`=1 after edge N).
- Throughput: one word per cycle while `out_ready`=1, in both modes.
- `SKID=1`: `in_ready` is a function of state only (registered); no path from `out_ready` to `in_ready`.
- `SKID=0`: combinational path from `out_ready` to `in_ready`.
- `out_valid` and `level` are decoded from state only; no combinational path from inputs.
- `out_data` is stable while `out_valid=1` and `out_ready=0`.
- Rule for the upstream side: once `in_valid` is raised it is not required to stay up; the block tolerates a valid being withdrawn.

## Structure
- Package `pipe_pkg`:
  - State typedef `pipe_state_t` with `ST_EMPTY`=2'd0, `ST_FULL`=2'd1, `ST_SKID`=2'd2.
  - Constant `PIPE_LEVEL_W`=2.
- Sub-module `pipe_data_reg` #(`WIDTH`, `RESET_VAL`): `clk`, `rst`, `clear`, `en`, `d`, `q`.
  - Priority: async reset, then clear, then enable.
  - Instantiated once for main, plus once for skid under `generate` when `SKID=1`.
- Top level: state register and next-state/enable decode only.

## Test plan
- Reset: assert `rst` mid-cycle with `RESET_VAL`=32'hDEADBEEF -> outputs change immediately, without waiting for a clock edge, to `out_valid`=0, `in_ready`=1, `out_data`=32'hDEADBEEF, `level`=0.
- Streaming: `out_ready`=1, push 1,2,3,4 back-to-back -> `out_data` is 1,2,3,4 on consecutive cycles, one cycle late; `level` stays 1.
- Skid fill (`SKID=1`): `out_ready`=0, push 5 then 6 -> `level`=2, `in_ready`=0. Raise `out_ready` -> outputs 5 then 6, `level` goes 2,1,0.
- No-skid backpressure (`SKID=0`): stage holds 7 with `out_ready`=0 -> `in_ready`=0 the same cycle and word 8 is not accepted. Raise `out_ready` -> 7 then 8.
- Flush at `level`=2 with `in_valid`=1 carrying 9 -> next cycle `level`=0, `out_valid`=0, `out_data`=`RESET_VAL`; 9 never appears at the output.
- Random stall scoreboard: 10,000 cycles of random `in_valid`/`out_ready`, both `SKID` values -> output order matches input order, no loss and no duplication.
